// File: rtl/nios_system_sysid_checker_if.sv
// Avalon-MM read channel between the sysid checker (master) and the system-ID slave.
interface nios_system_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/nios_system_sysid_checker.sv
// Reads the system-ID slave (word 0 = ID, word 1 = timestamp), compares against build-time values
// and reports pass/fail/timeout. Define SYSID_CHECK_RDV_EN for a pipelined master using readdatavalid.
module nios_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1581686681,
    parameter int          TIMEOUT_CYCLES     = 1024,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               start,
    nios_system_sysid_checker_if.master        avm,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic                               id_mismatch,
    output logic                               ts_mismatch,
    output logic                               timeout,
    output logic [31:0]                        id_value,
    output logic [31:0]                        ts_value
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ID   = 3'd1,
        S_WAIT_ID = 3'd2,
        S_RD_TS   = 3'd3,
        S_WAIT_TS = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               read_q, read_d;
    logic               addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               id_mm_q, id_mm_d;
    logic               ts_mm_q, ts_mm_d;
    logic               to_q, to_d;
    logic [31:0]        id_val_q, id_val_d;
    logic [31:0]        ts_val_q, ts_val_d;

    logic               accept_s;
    logic               expired_s;
    logic [CNT_W-1:0]   cnt_inc_s;

    function automatic logic word_differs(input logic [31:0] got, input logic [31:0] want);
        word_differs = (got != want);
    endfunction

    assign accept_s  = read_q & ~avm.avm_waitrequest;
    assign expired_s = (cnt_q == CNT_LAST);
    assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1});

`ifndef SYSID_CHECK_RDV_EN
    logic unused_rdv_s;
    assign unused_rdv_s = avm.avm_readdatavalid;
`endif

    // Next-state, bus request, capture and compare logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        read_d   = 1'b0;
        addr_d   = addr_q;
        pass_d   = pass_q;
        id_mm_d  = id_mm_q;
        ts_mm_d  = ts_mm_q;
        to_d     = to_q;
        id_val_d = id_val_q;
        ts_val_d = ts_val_q;

        case (state_q)
            S_IDLE: begin
                if (AUTO_START || start) begin
                    state_d = S_RD_ID;
                    cnt_d   = {CNT_W{1'b0}};
                    read_d  = 1'b1;
                    addr_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RD_ID: begin
                cnt_d = cnt_inc_s;
                if (accept_s) begin
`ifdef SYSID_CHECK_RDV_EN
                    state_d = S_WAIT_ID;
                    read_d  = 1'b0;
`else
                    id_val_d = avm.avm_readdata;
                    id_mm_d  = word_differs(avm.avm_readdata, EXPECTED_ID);
                    state_d  = S_RD_TS;
                    cnt_d    = {CNT_W{1'b0}};
                    read_d   = 1'b1;
                    addr_d   = 1'b1;
`endif
                end else if (expired_s) begin
                    // An ID timeout skips the timestamp read entirely
                    to_d    = 1'b1;
                    pass_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    read_d = 1'b1;
                end
            end

`ifdef SYSID_CHECK_RDV_EN
            S_WAIT_ID: begin
                cnt_d = cnt_inc_s;
                if (avm.avm_readdatavalid) begin
                    id_val_d = avm.avm_readdata;
                    id_mm_d  = word_differs(avm.avm_readdata, EXPECTED_ID);
                    state_d  = S_RD_TS;
                    cnt_d    = {CNT_W{1'b0}};
                    read_d   = 1'b1;
                    addr_d   = 1'b1;
                end else if (expired_s) begin
                    to_d    = 1'b1;
                    pass_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT_ID;
                end
            end
`endif

            S_RD_TS: begin
                cnt_d = cnt_inc_s;
                if (accept_s) begin
`ifdef SYSID_CHECK_RDV_EN
                    state_d = S_WAIT_TS;
                    read_d  = 1'b0;
`else
                    ts_val_d = avm.avm_readdata;
                    ts_mm_d  = word_differs(avm.avm_readdata, EXPECTED_TIMESTAMP);
                    pass_d   = ~id_mm_q & ~word_differs(avm.avm_readdata, EXPECTED_TIMESTAMP);
                    state_d  = S_DONE;
`endif
                end else if (expired_s) begin
                    to_d    = 1'b1;
                    pass_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    read_d = 1'b1;
                end
            end

`ifdef SYSID_CHECK_RDV_EN
            S_WAIT_TS: begin
                cnt_d = cnt_inc_s;
                if (avm.avm_readdatavalid) begin
                    ts_val_d = avm.avm_readdata;
                    ts_mm_d  = word_differs(avm.avm_readdata, EXPECTED_TIMESTAMP);
                    pass_d   = ~id_mm_q & ~word_differs(avm.avm_readdata, EXPECTED_TIMESTAMP);
                    state_d  = S_DONE;
                end else if (expired_s) begin
                    to_d    = 1'b1;
                    pass_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT_TS;
                end
            end
`endif

            S_DONE: begin
                // A rerun wipes every result so stale flags never leak into the new check
                if (start) begin
                    state_d  = S_RD_ID;
                    cnt_d    = {CNT_W{1'b0}};
                    read_d   = 1'b1;
                    addr_d   = 1'b0;
                    pass_d   = 1'b0;
                    id_mm_d  = 1'b0;
                    ts_mm_d  = 1'b0;
                    to_d     = 1'b0;
                    id_val_d = 32'd0;
                    ts_val_d = 32'd0;
                end else begin
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                addr_d  = 1'b0;
            end
        endcase
    end

    // Status flags derived from the upcoming state so they are registered alongside it
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if ((state_d == S_IDLE) || (state_d == S_DONE)) begin
            busy_d = 1'b0;
        end else begin
            busy_d = 1'b1;
        end
        if (state_d == S_DONE) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            read_q   <= 1'b0;
            addr_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            id_mm_q  <= 1'b0;
            ts_mm_q  <= 1'b0;
            to_q     <= 1'b0;
            id_val_q <= 32'd0;
            ts_val_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            read_q   <= read_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            id_mm_q  <= id_mm_d;
            ts_mm_q  <= ts_mm_d;
            to_q     <= to_d;
            id_val_q <= id_val_d;
            ts_val_q <= ts_val_d;
        end
    end

    assign avm.avm_read    = read_q;
    assign avm.avm_address = addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign id_mismatch     = id_mm_q;
    assign ts_mismatch     = ts_mm_q;
    assign timeout         = to_q;
    assign id_value        = id_val_q;
    assign ts_value        = ts_val_q;

endmodule
